// File: rtl/weighted_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weighted_mixer_pkg
// Description : Shared types, limits and sizing helper for the weighted mixer.
// Revision    : 1.0 - initial release
// ============================================================================
package weighted_mixer_pkg;

    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [15:0] gain_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } mixer_state_t;

    // Full product width plus headroom for summing n products.
    function automatic int acc_width(input int n);
        return 32 + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_saturate.sv
`default_nettype none
// ============================================================================
// Module      : audio_saturate
// Description : Arithmetic right shift (floor) then clamp to signed 16 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_saturate
    import weighted_mixer_pkg::*;
#(
    parameter int IN_W  = 34,
    parameter int SHIFT = 14
) (
    input  logic signed [IN_W-1:0] i_value,
    output sample_t                o_sample,
    output logic                   o_clipped
);

    localparam logic signed [IN_W-1:0] c_max = IN_W'(SAMPLE_MAX);
    localparam logic signed [IN_W-1:0] c_min = IN_W'(SAMPLE_MIN);

    logic signed [IN_W-1:0] w_shifted;

    assign w_shifted = i_value >>> SHIFT;

    always_comb begin
        o_sample  = w_shifted[15:0];
        o_clipped = 1'b0;
        if (w_shifted > c_max) begin
            o_sample  = 16'sh7FFF;
            o_clipped = 1'b1;
        end else if (w_shifted < c_min) begin
            o_sample  = 16'sh8000;
            o_clipped = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/weighted_summing_mixer.sv
`default_nettype none
// ============================================================================
// Module      : weighted_summing_mixer
// Description : Time-shared MAC summing NUM_CHANNELS gain-weighted voices into
//               one saturated 16-bit sample per audio_clk_en.
//               Optional macro WEIGHTED_MIXER_CLIP_EN adds clip / clip_count.
// Revision    : 1.0 - initial release
// ============================================================================
module weighted_summing_mixer
    import weighted_mixer_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int GAIN_FRAC_BITS = 14
) (
    input  logic                      clk,
    input  logic                      I_RSTn,
    input  logic                      audio_clk_en,
    input  logic [NUM_CHANNELS*16-1:0] in,
    input  logic [NUM_CHANNELS*16-1:0] gain,
    output logic signed [15:0]        out,
    output logic                      out_valid,
`ifdef WEIGHTED_MIXER_CLIP_EN
    output logic                      clip,
    output logic [7:0]                clip_count,
`endif
    output logic                      overrun
);

    localparam int ACC_W = acc_width(NUM_CHANNELS);
    localparam int CNT_W = $clog2(NUM_CHANNELS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_CHANNELS - 1);

    sample_t                 w_in   [NUM_CHANNELS];
    gain_t                   w_gain [NUM_CHANNELS];
    logic signed [31:0]      w_prod;
    sample_t                 w_sat;
    logic signed [ACC_W-1:0] w_prod_ext;

    mixer_state_t            r_state;
    logic [CNT_W-1:0]        r_cnt;
    sample_t                 r_snap_in   [NUM_CHANNELS];
    gain_t                   r_snap_gain [NUM_CHANNELS];
    logic signed [31:0]      r_prod;
    logic signed [ACC_W-1:0] r_acc;
    sample_t                 r_out;
    logic                    r_out_valid;
    logic                    r_overrun;

    generate
        for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_unpack
            assign w_in[k]   = in[16*k +: 16];
            assign w_gain[k] = gain[16*k +: 16];
        end
    endgenerate

    assign w_prod     = r_snap_in[r_cnt] * r_snap_gain[r_cnt];
    assign w_prod_ext = {{(ACC_W-32){r_prod[31]}}, r_prod};

`ifdef WEIGHTED_MIXER_CLIP_EN
    logic       w_clipped;
    logic       r_clip;
    logic [7:0] r_clip_count;
`else
    logic       w_unused_clip;
`endif

    audio_saturate #(
        .IN_W  (ACC_W),
        .SHIFT (GAIN_FRAC_BITS)
    ) u_sat (
        .i_value   (r_acc),
        .o_sample  (w_sat),
`ifdef WEIGHTED_MIXER_CLIP_EN
        .o_clipped (w_clipped)
`else
        .o_clipped (w_unused_clip)
`endif
    );

    // The product register adds one cycle of pipeline, so the accumulator
    // always folds in the product from the previous MAC cycle.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                r_snap_in[k]   <= '0;
                r_snap_gain[k] <= '0;
            end
`ifdef WEIGHTED_MIXER_CLIP_EN
            r_clip       <= 1'b0;
            r_clip_count <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            r_overrun   <= audio_clk_en && (r_state != IDLE);
`ifdef WEIGHTED_MIXER_CLIP_EN
            r_clip      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (audio_clk_en) begin
                        for (int k = 0; k < NUM_CHANNELS; k++) begin
                            r_snap_in[k]   <= w_in[k];
                            r_snap_gain[k] <= w_gain[k];
                        end
                        r_acc   <= '0;
                        r_prod  <= '0;
                        r_cnt   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_prod <= w_prod;
                    r_acc  <= r_acc + w_prod_ext;
                    if (r_cnt == c_last) begin
                        r_state <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= OUTPUT;
                end
                OUTPUT: begin
                    r_out       <= w_sat;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= IDLE;
`ifdef WEIGHTED_MIXER_CLIP_EN
                    if (w_clipped) begin
                        r_clip <= 1'b1;
                        if (r_clip_count != 8'hFF) begin
                            r_clip_count <= r_clip_count + 8'd1;
                        end
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
`ifdef WEIGHTED_MIXER_CLIP_EN
    assign clip       = r_clip;
    assign clip_count = r_clip_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weighted_summing_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_summing_mixer
// Description : Scoreboard bench for weighted_summing_mixer (4 channels, Q2.14).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weighted_summing_mixer;

    logic              clk;
    logic              I_RSTn;
    logic              audio_clk_en;
    logic [63:0]       in_v;
    logic [63:0]       gain_v;
    logic signed [15:0] out;
    logic              out_valid;
    logic              overrun;
`ifdef WEIGHTED_MIXER_CLIP_EN
    logic              clip;
    logic [7:0]        clip_count;
    int                exp_cc;
`endif

    int checks;
    int errors;
    int cyc;
    int valid_cnt;
    int ovr_cnt;

    int q_out[$];
    int q_cyc[$];
    int q_clip[$];

    weighted_summing_mixer #(
        .NUM_CHANNELS   (4),
        .GAIN_FRAC_BITS (14)
    ) dut (
        .clk          (clk),
        .I_RSTn       (I_RSTn),
        .audio_clk_en (audio_clk_en),
        .in           (in_v),
        .gain         (gain_v),
        .out          (out),
        .out_valid    (out_valid),
`ifdef WEIGHTED_MIXER_CLIP_EN
        .clip         (clip),
        .clip_count   (clip_count),
`endif
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {c3[15:0], c2[15:0], c1[15:0], c0[15:0]};
    endfunction

    // Monitor: pops the scoreboard on every out_valid.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (out_valid) begin
            valid_cnt++;
            if (q_out.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                int eo, ec, ek;
                eo = q_out.pop_front();
                ec = q_cyc.pop_front();
                ek = q_clip.pop_front();
                check("out_value", int'(out), eo);
                check("latency_cycle", cyc, ec);
`ifdef WEIGHTED_MIXER_CLIP_EN
                check("clip", int'(clip), ek);
                if (ek != 0 && exp_cc < 255) exp_cc++;
                check("clip_count", int'(clip_count), exp_cc);
`else
                if (ek > 1) check("clip_flag_range", ek, 1);
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge right after edge T0.
    task automatic send(input logic [63:0] vi, input logic [63:0] vg,
                        input int exp, input int exp_clip, input bit push);
        in_v         = vi;
        gain_v       = vg;
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            q_out.push_back(exp);
            q_cyc.push_back(cyc + 6);
            q_clip.push_back(exp_clip);
        end
        @(negedge clk);
        audio_clk_en = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int vc;
        int oc;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        valid_cnt    = 0;
        ovr_cnt      = 0;
`ifdef WEIGHTED_MIXER_CLIP_EN
        exp_cc       = 0;
`endif
        I_RSTn       = 1'b0;
        audio_clk_en = 1'b0;
        in_v         = '0;
        gain_v       = '0;
        gap(5);
        I_RSTn = 1'b1;
        gap(1);
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_overrun", int'(overrun), 0);

        // Reset mid-sequence: sample is aborted.
        vc = valid_cnt;
        send(pk(1234, 0, 0, 0), pk(16384, 0, 0, 0), 0, 0, 1'b0);
        gap(1);
        I_RSTn = 1'b0;
        gap(2);
        I_RSTn = 1'b1;
        gap(10);
        check("abort_no_valid", valid_cnt, vc);
        check("abort_out_zero", int'(out), 0);

        // Single channel and weighted sums.
        send(pk(1000, 0, 0, 0), pk(16384, 0, 0, 0), 1000, 0, 1'b1);
        gap(10);
        send(pk(4000, -2000, 1000, 1000), pk(8192, 8192, 8192, 8192), 2000, 0, 1'b1);
        gap(10);
        send(pk(-1, 0, 0, 0), pk(8192, 0, 0, 0), -1, 0, 1'b1);
        gap(10);

        // Saturation both ways.
        send(pk(32767, 32767, 32767, 32767), pk(16384, 16384, 16384, 16384), 32767, 1, 1'b1);
        gap(10);
        send(pk(-32768, -32768, -32768, -32768), pk(16384, 16384, 16384, 16384), -32768, 1, 1'b1);
        gap(10);

        // Isolation and overrun.
        oc = ovr_cnt;
        vc = valid_cnt;
        send(pk(1000, 0, 0, 0), pk(16384, 0, 0, 0), 1000, 0, 1'b1);
        in_v = pk(5000, 0, 0, 0);
        gap(2);
        audio_clk_en = 1'b1;
        gap(1);
        audio_clk_en = 1'b0;
        gap(6);
        send(pk(5000, 0, 0, 0), pk(16384, 0, 0, 0), 5000, 0, 1'b1);
        gap(10);
        check("iso_overrun_once", ovr_cnt - oc, 1);
        check("iso_valid_count", valid_cnt - vc, 2);

        // Back-to-back at minimum spacing.
        oc = ovr_cnt;
        vc = valid_cnt;
        for (int i = 0; i < 20; i++) begin
            send(pk(100 * i - 700, 3, 3, 3), pk(16384, 0, 0, 0), 100 * i - 700, 0, 1'b1);
            if (i != 19) gap(6);
        end
        gap(10);
        check("b2b_valid_count", valid_cnt - vc, 20);
        check("b2b_no_overrun", ovr_cnt - oc, 0);

        for (int t = 0; t < 50 && q_out.size() != 0; t++) @(negedge clk);
        check("scoreboard_drained", q_out.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
